i2c_cmd_writer: RTL and testbench
=================================

I2C_CMD_WRITER -- requirements
Module: i2c_cmd_writer

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 125, meaning CLOCK cycles per quarter-SCL tick (50 MHz -> 100 kHz SCL).
REQ-002 The block SHALL have port CLOCK  input  1  system clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port DATA  input  24  {slave_addr+W, sub_addr, reg_data}, sent MSB first.
REQ-005 The block SHALL have port GO  input  1  asynchronous start request; a rising edge starts one transfer.
REQ-006 The block SHALL have port END  output  1  high = idle/transfer complete; low while busy.
REQ-007 The block SHALL have port ACK_ERR  output  1  high = at least one NACK in the last transfer.
REQ-008 The block SHALL have port SCL  output  1  I2C clock level (1 = released/high).
REQ-009 The block SHALL have port SDA_OE  output  1  1 = pull SDA low; 0 = release.
REQ-010 The block SHALL have port SDA_IN  input  1  sampled SDA line level.

Function
REQ-011 GO SHALL pass through a 2-flop synchronizer; rising edge detection SHALL use the synchronized value.
REQ-012 A prescaler SHALL emit a one-CLOCK tick every CLK_DIV cycles, free-running only while not IDLE, cleared to 0 on entering IDLE.
REQ-013 States SHALL be IDLE, START, BIT, STOP, DONE; all non-IDLE states advance only on tick.
REQ-014 IDLE: SCL=1, SDA_OE=0, END=1; a GO rising edge SHALL latch DATA into a 24-bit shift register, clear ACK_ERR, drop END next cycle, go to START.
REQ-015 START, 4 ticks: q0 SDA released/SCL high; q1 SDA_OE=1; q2 hold; q3 SCL=0; then BIT.
REQ-016 BIT SHALL run 27 slots (3 bytes x (8 data + 1 ack)), 4 ticks each: q0 SCL=0 and SDA set; q1 SCL=1; q2 sample; q3 SCL=0.
REQ-017 Data slot: SDA_OE = NOT current MSB; shift left by one at q3.
REQ-018 Ack slot: SDA_OE=0; SDA_IN=1 at q2 SHALL set ACK_ERR (sticky for the transfer); the transfer SHALL continue regardless.
REQ-019 STOP, 4 ticks: q0 SDA_OE=1, SCL=0; q1 SCL=1; q2 SDA_OE=0; q3 hold; then DONE.
REQ-020 DONE SHALL last one CLOCK cycle, set END=1, return to IDLE.
REQ-021 A full transfer SHALL take 116 ticks (4+108+4); END SHALL rise 1 CLOCK after the final STOP tick.
REQ-022 GO edges while not IDLE SHALL be ignored and not queued; GO held high SHALL NOT retrigger.
REQ-023 DATA SHALL be sampled only at transfer start; later changes SHALL NOT affect the transfer.
REQ-024 Bit and tick counters SHALL be sized exactly; no wrap-around SHALL occur within a transfer.

Reset
REQ-025 rst_n=0 at a CLOCK edge SHALL force IDLE, END=1, ACK_ERR=0, SCL=1, SDA_OE=0, clear counters and synchronizer, including mid-transfer.
REQ-026 The first GO rising edge seen after reset release SHALL start a normal transfer; a GO held high through reset SHALL NOT start one.

Configuration
REQ-027 With I2C_NACK_RETRY_EN defined, a transfer with ACK_ERR set SHALL, after STOP, restart from START with the latched DATA, up to 2 retries; END SHALL stay low until success or retries are exhausted; ACK_ERR SHALL reflect the final attempt only.
REQ-028 Without I2C_NACK_RETRY_EN, no retry SHALL occur; END SHALL rise after the first attempt.

Verification
REQ-029 CLK_DIV=4, DATA=24'h34_1201, slave ACKs all slots -> SCL/SDA decode as bytes 34,12,01; START/STOP correct; END low for exactly 464+1 CLOCK cycles; ACK_ERR=0.
REQ-030 Slave NACKs second byte -> ACK_ERR=1 at END rise; all 27 slots still clocked; STOP issued.
REQ-031 With I2C_NACK_RETRY_EN, slave NACKs every time -> exactly 3 START/STOP pairs; END rises once; ACK_ERR=1. Same case without the macro -> 1 pair.
REQ-032 Second GO edge at tick 50 of a transfer, with DATA changed to 24'h34_0C00 -> ignored; bytes on the wire remain 34,12,01.
REQ-033 rst_n asserted at tick 60 -> next CLOCK gives SCL=1, SDA_OE=0, END=1, ACK_ERR=0; a fresh GO then yields a clean full transfer.

Source files
------------

// File: rtl/i2c_cmd_writer.sv
// Three-byte I2C write master: {slave_addr+W, sub_addr, reg_data} sent MSB first.
// Define I2C_NACK_RETRY_EN to restart a NACKed transfer up to two more times.
module i2c_cmd_writer #(
  parameter int CLK_DIV = 125
) (
  input  logic        CLOCK,
  input  logic        rst_n,
  input  logic [23:0] DATA,
  input  logic        GO,
  output logic        END,
  output logic        ACK_ERR,
  output logic        SCL,
  output logic        SDA_OE,
  input  logic        SDA_IN
);

  localparam int               DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       ACK_BIT   = 4'd8;
  localparam logic [1:0]       LAST_BYTE = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_STOP,
    S_DONE
  } state_t;

  state_t           r_state, w_state_next;
  logic [DIV_W-1:0] r_div, w_div_next;
  logic [1:0]       r_q, w_q_next;
  logic [3:0]       r_bit, w_bit_next;
  logic [1:0]       r_byte, w_byte_next;
  logic [23:0]      r_shift, w_shift_next;
  logic             r_end, w_end_next;
  logic             r_ack_err, w_ack_err_next;
  logic             r_scl, w_scl_next;
  logic             r_sda_oe, w_sda_oe_next;

  logic             r_go_s1, r_go_s2, r_go_d, r_armed;
  logic [1:0]       r_flush;
  logic             r_sda_s1, r_sda_s2;
  logic             w_go_rise, w_tick;

`ifdef I2C_NACK_RETRY_EN
  localparam logic [1:0] MAX_RETRY = 2'd2;
  logic [23:0] r_data, w_data_next;
  logic [1:0]  r_retry, w_retry_next;
`endif

  // r_armed only sets once the flushed synchronizer has shown GO low, so a
  // GO held high across reset can never look like a fresh rising edge.
  always_ff @(posedge CLOCK) begin
    if (!rst_n) begin
      r_go_s1  <= 1'b0;
      r_go_s2  <= 1'b0;
      r_go_d   <= 1'b0;
      r_flush  <= 2'b00;
      r_armed  <= 1'b0;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
    end else begin
      r_go_s1  <= GO;
      r_go_s2  <= r_go_s1;
      r_go_d   <= r_go_s2;
      r_flush  <= {r_flush[0], 1'b1};
      if (r_flush[1] && !r_go_s2)
        r_armed <= 1'b1;
      r_sda_s1 <= SDA_IN;
      r_sda_s2 <= r_sda_s1;
    end
  end

  assign w_go_rise = r_armed & r_go_s2 & ~r_go_d;
  assign w_tick    = (r_div == DIV_LAST);

  always_ff @(posedge CLOCK) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_q       <= 2'd0;
      r_bit     <= 4'd0;
      r_byte    <= 2'd0;
      r_shift   <= 24'd0;
      r_end     <= 1'b1;
      r_ack_err <= 1'b0;
      r_scl     <= 1'b1;
      r_sda_oe  <= 1'b0;
`ifdef I2C_NACK_RETRY_EN
      r_data    <= 24'd0;
      r_retry   <= 2'd0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_div     <= w_div_next;
      r_q       <= w_q_next;
      r_bit     <= w_bit_next;
      r_byte    <= w_byte_next;
      r_shift   <= w_shift_next;
      r_end     <= w_end_next;
      r_ack_err <= w_ack_err_next;
      r_scl     <= w_scl_next;
      r_sda_oe  <= w_sda_oe_next;
`ifdef I2C_NACK_RETRY_EN
      r_data    <= w_data_next;
      r_retry   <= w_retry_next;
`endif
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_div_next     = '0;
    w_q_next       = r_q;
    w_bit_next     = r_bit;
    w_byte_next    = r_byte;
    w_shift_next   = r_shift;
    w_end_next     = r_end;
    w_ack_err_next = r_ack_err;
`ifdef I2C_NACK_RETRY_EN
    w_data_next    = r_data;
    w_retry_next   = r_retry;
`endif
    if (r_state != S_IDLE && r_state != S_DONE)
      w_div_next = w_tick ? '0 : r_div + 1'b1;

    case (r_state)
      S_IDLE: begin
        if (w_go_rise) begin
          w_state_next   = S_START;
          w_q_next       = 2'd0;
          w_bit_next     = 4'd0;
          w_byte_next    = 2'd0;
          w_shift_next   = DATA;
          w_ack_err_next = 1'b0;
          w_end_next     = 1'b0;
`ifdef I2C_NACK_RETRY_EN
          w_data_next    = DATA;
          w_retry_next   = 2'd0;
`endif
        end
      end
      S_START: begin
        if (w_tick) begin
          w_q_next = r_q + 2'd1;
          if (r_q == 2'd3) begin
            w_state_next = S_BIT;
            w_bit_next   = 4'd0;
            w_byte_next  = 2'd0;
          end
        end
      end
      S_BIT: begin
        if (w_tick) begin
          w_q_next = r_q + 2'd1;
          if (r_q == 2'd2 && r_bit == ACK_BIT && r_sda_s2)
            w_ack_err_next = 1'b1;
          if (r_q == 2'd3) begin
            if (r_bit != ACK_BIT) begin
              w_shift_next = {r_shift[22:0], 1'b0};
              w_bit_next   = r_bit + 4'd1;
            end else begin
              w_bit_next = 4'd0;
              if (r_byte == LAST_BYTE)
                w_state_next = S_STOP;
              else
                w_byte_next = r_byte + 2'd1;
            end
          end
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_q_next = r_q + 2'd1;
          if (r_q == 2'd3) begin
`ifdef I2C_NACK_RETRY_EN
            if (r_ack_err && r_retry != MAX_RETRY) begin
              w_state_next   = S_START;
              w_retry_next   = r_retry + 2'd1;
              w_ack_err_next = 1'b0;
              w_shift_next   = r_data;
            end else begin
              w_state_next = S_DONE;
            end
`else
            w_state_next = S_DONE;
`endif
          end
        end
      end
      S_DONE: begin
        w_end_next   = 1'b1;
        w_q_next     = 2'd0;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Line levels are decoded from the next state so they register in step with it.
  always_comb begin
    w_scl_next    = 1'b1;
    w_sda_oe_next = 1'b0;
    case (w_state_next)
      S_START: begin
        w_scl_next    = (w_q_next != 2'd3);
        w_sda_oe_next = (w_q_next != 2'd0);
      end
      S_BIT: begin
        w_scl_next    = (w_q_next == 2'd1) || (w_q_next == 2'd2);
        w_sda_oe_next = (w_bit_next != ACK_BIT) && !w_shift_next[23];
      end
      S_STOP: begin
        w_scl_next    = (w_q_next != 2'd0);
        w_sda_oe_next = (w_q_next <= 2'd1);
      end
      default: begin
        w_scl_next    = 1'b1;
        w_sda_oe_next = 1'b0;
      end
    endcase
  end

  assign END     = r_end;
  assign ACK_ERR = r_ack_err;
  assign SCL     = r_scl;
  assign SDA_OE  = r_sda_oe;

endmodule

// File: tb/tb_i2c_cmd_writer.sv
// Bench for i2c_cmd_writer: a behavioural I2C slave decodes the bus and answers
// ACK/NACK per byte; expectations come from DATA, the NACK mask and the tick budget.
module tb_i2c_cmd_writer;

  localparam int CLK_DIV = 4;
  localparam int TICKS   = 116;
`ifdef I2C_NACK_RETRY_EN
  localparam int MAX_ATTEMPTS = 3;
`else
  localparam int MAX_ATTEMPTS = 1;
`endif
  localparam int LIMIT = MAX_ATTEMPTS * TICKS * CLK_DIV + 50;

  logic        CLOCK = 1'b0;
  logic        rst_n = 1'b0;
  logic        GO    = 1'b0;
  logic [23:0] DATA  = 24'd0;
  logic        end_o, ack_err, scl, sda_oe, sda_in;
  logic        sda_line;
  logic        slave_pull = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  i2c_cmd_writer #(.CLK_DIV(CLK_DIV)) dut (
    .CLOCK   (CLOCK),
    .rst_n   (rst_n),
    .DATA    (DATA),
    .GO      (GO),
    .END     (end_o),
    .ACK_ERR (ack_err),
    .SCL     (scl),
    .SDA_OE  (sda_oe),
    .SDA_IN  (sda_in)
  );

  assign sda_line = ~(sda_oe | slave_pull);
  assign sda_in   = sda_line;

  always #5 CLOCK = ~CLOCK;

  // Slave / bus monitor: START, STOP, bytes on SCL rise, ACK driven while SCL low.
  int         n_start = 0, n_stop = 0, bitcnt = 0, byte_in_att = 0;
  logic [7:0] cur = 8'd0;
  logic [7:0] bytes[$];
  logic [2:0] nack_mask = 3'b000;
  logic       p_scl = 1'b1, p_sda = 1'b1;

  always @(scl or sda_line) begin
    if (p_scl === 1'b1 && scl === 1'b1 && p_sda === 1'b1 && sda_line === 1'b0) begin
      n_start++;
      bitcnt      = 0;
      byte_in_att = 0;
    end else if (p_scl === 1'b1 && scl === 1'b1 && p_sda === 1'b0 && sda_line === 1'b1) begin
      n_stop++;
    end else if (p_scl === 1'b0 && scl === 1'b1) begin
      if (bitcnt < 8) cur = {cur[6:0], sda_line};
      bitcnt++;
      if (bitcnt == 9) begin
        bytes.push_back(cur);
        bitcnt = 0;
        byte_in_att++;
      end
    end else if (p_scl === 1'b1 && scl === 1'b0) begin
      slave_pull = (bitcnt == 8) && (byte_in_att < 3) && !nack_mask[byte_in_att];
    end
    p_scl = scl;
    p_sda = sda_line;
  end

  // mode 0: plain; 1: GO re-edge + DATA change at tick 50; 2: reset at tick 60.
  task automatic do_transfer(input logic [23:0] data, input logic [2:0] mask, input int mode,
                             output int low, output int st0, output int sp0, output int b0,
                             output bit tout);
    int w;
    nack_mask = mask;
    DATA      = data;
    GO        = 1'b0;
    repeat (4) @(negedge CLOCK);
    st0  = n_start;
    sp0  = n_stop;
    b0   = bytes.size();
    GO   = 1'b1;
    tout = 1'b0;
    low  = 0;
    w    = 0;
    while (end_o !== 1'b0 && w < 20) begin
      @(negedge CLOCK);
      w++;
    end
    if (end_o !== 1'b0) begin
      tout = 1'b1;
      return;
    end
    low = 1;
    while (low < LIMIT) begin
      if (mode == 1 && low == 50 * CLK_DIV) begin
        GO   = 1'b0;
        DATA = 24'h340C00;
      end
      if (mode == 1 && low == 50 * CLK_DIV + 3) GO = 1'b1;
      if (mode == 2 && low == 60 * CLK_DIV) begin
        rst_n = 1'b0;
        @(posedge CLOCK);
        #1;
        return;
      end
      @(negedge CLOCK);
      if (end_o !== 1'b0) break;
      low++;
    end
    if (low >= LIMIT) tout = 1'b1;
  endtask

  task automatic test_reset();
    n_checks++; if (end_o !== 1'b1) $display("FAIL reset_end: got %b want 1", end_o); else n_pass++;
    n_checks++; if (ack_err !== 1'b0) $display("FAIL reset_ack_err: got %b want 0", ack_err); else n_pass++;
    n_checks++; if (scl !== 1'b1) $display("FAIL reset_scl: got %b want 1", scl); else n_pass++;
    n_checks++; if (sda_oe !== 1'b0) $display("FAIL reset_sda_oe: got %b want 0", sda_oe); else n_pass++;
    $display("reset: END=%b ACK_ERR=%b SCL=%b SDA_OE=%b", end_o, ack_err, scl, sda_oe);
  endtask

  task automatic test_basic();
    int low, st0, sp0, b0, s_before;
    bit tout;
    logic [7:0] exp_b[3] = '{8'h34, 8'h12, 8'h01};
    do_transfer(24'h341201, 3'b000, 0, low, st0, sp0, b0, tout);
    n_checks++; if (tout) $display("FAIL basic_timeout: END low %0d cycles, no completion", low); else n_pass++;
    n_checks++; if (low !== TICKS * CLK_DIV + 1) $display("FAIL basic_end_low: got %0d want %0d", low, TICKS * CLK_DIV + 1); else n_pass++;
    n_checks++; if (ack_err !== 1'b0) $display("FAIL basic_ack_err: got %b want 0", ack_err); else n_pass++;
    n_checks++; if (n_start - st0 !== 1) $display("FAIL basic_starts: got %0d want 1", n_start - st0); else n_pass++;
    n_checks++; if (n_stop - sp0 !== 1) $display("FAIL basic_stops: got %0d want 1", n_stop - sp0); else n_pass++;
    n_checks++; if (bytes.size() - b0 !== 3) $display("FAIL basic_nbytes: got %0d want 3", bytes.size() - b0); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (bytes[b0 + k] !== exp_b[k]) $display("FAIL basic_byte%0d: got %02h want %02h", k, bytes[b0 + k], exp_b[k]);
      else n_pass++;
    end
    n_checks++; if (scl !== 1'b1 || sda_oe !== 1'b0) $display("FAIL basic_idle_bus: got SCL=%b SDA_OE=%b want 1/0", scl, sda_oe); else n_pass++;
    $display("xfer basic data=341201 low=%0d ack_err=%b starts=%0d", low, ack_err, n_start - st0);
    s_before = n_start;
    repeat (40) @(negedge CLOCK);
    n_checks++;
    if (end_o !== 1'b1 || n_start !== s_before)
      $display("FAIL go_held_retrigger: got END=%b starts=%0d want END=1 starts=0", end_o, n_start - s_before);
    else n_pass++;
  endtask

  task automatic test_nack();
    logic [2:0] masks[3] = '{3'b010, 3'b111, 3'b001};
    logic [23:0] d;
    int low, st0, sp0, b0;
    bit tout;
    for (int i = 0; i < 3; i++) begin
      d = 24'h341201;
      do_transfer(d, masks[i], 0, low, st0, sp0, b0, tout);
      n_checks++; if (tout) $display("FAIL nack%0d_timeout: END low %0d cycles", i, low); else n_pass++;
      n_checks++; if (ack_err !== 1'b1) $display("FAIL nack%0d_ack_err: got %b want 1", i, ack_err); else n_pass++;
      n_checks++;
      if (low !== MAX_ATTEMPTS * TICKS * CLK_DIV + 1)
        $display("FAIL nack%0d_end_low: got %0d want %0d", i, low, MAX_ATTEMPTS * TICKS * CLK_DIV + 1);
      else n_pass++;
      n_checks++; if (n_start - st0 !== MAX_ATTEMPTS) $display("FAIL nack%0d_starts: got %0d want %0d", i, n_start - st0, MAX_ATTEMPTS); else n_pass++;
      n_checks++; if (n_stop - sp0 !== MAX_ATTEMPTS) $display("FAIL nack%0d_stops: got %0d want %0d", i, n_stop - sp0, MAX_ATTEMPTS); else n_pass++;
      n_checks++; if (bytes.size() - b0 !== 3 * MAX_ATTEMPTS) $display("FAIL nack%0d_nbytes: got %0d want %0d", i, bytes.size() - b0, 3 * MAX_ATTEMPTS); else n_pass++;
      for (int k = 0; k < 3 * MAX_ATTEMPTS; k++) begin
        n_checks++;
        if (bytes[b0 + k] !== d[23 - 8 * (k % 3) -: 8])
          $display("FAIL nack%0d_byte%0d: got %02h want %02h", i, k, bytes[b0 + k], d[23 - 8 * (k % 3) -: 8]);
        else n_pass++;
      end
      $display("xfer nack mask=%03b low=%0d ack_err=%b starts=%0d", masks[i], low, ack_err, n_start - st0);
    end
  endtask

  task automatic test_random();
    logic [23:0] d;
    logic [2:0]  m;
    int low, st0, sp0, b0, att;
    bit tout;
    for (int i = 0; i < 5; i++) begin
      d = 24'($urandom());
      m = (i % 2 == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      att = (m != 3'b000) ? MAX_ATTEMPTS : 1;
      do_transfer(d, m, 0, low, st0, sp0, b0, tout);
      n_checks++; if (tout) $display("FAIL rand%0d_timeout: END low %0d cycles", i, low); else n_pass++;
      n_checks++; if (ack_err !== (m != 3'b000)) $display("FAIL rand%0d_ack_err: got %b want %b", i, ack_err, (m != 3'b000)); else n_pass++;
      n_checks++; if (low !== att * TICKS * CLK_DIV + 1) $display("FAIL rand%0d_end_low: got %0d want %0d", i, low, att * TICKS * CLK_DIV + 1); else n_pass++;
      n_checks++; if (n_start - st0 !== att || n_stop - sp0 !== att) $display("FAIL rand%0d_start_stop: got %0d/%0d want %0d", i, n_start - st0, n_stop - sp0, att); else n_pass++;
      for (int k = 0; k < 3 * att; k++) begin
        n_checks++;
        if (bytes[b0 + k] !== d[23 - 8 * (k % 3) -: 8])
          $display("FAIL rand%0d_byte%0d: got %02h want %02h", i, k, bytes[b0 + k], d[23 - 8 * (k % 3) -: 8]);
        else n_pass++;
      end
      $display("xfer random data=%06h mask=%03b low=%0d ack_err=%b", d, m, low, ack_err);
    end
  endtask

  task automatic test_go_ignored();
    int low, st0, sp0, b0;
    bit tout;
    logic [7:0] exp_b[3] = '{8'h34, 8'h12, 8'h01};
    do_transfer(24'h341201, 3'b000, 1, low, st0, sp0, b0, tout);
    n_checks++; if (tout) $display("FAIL goign_timeout: END low %0d cycles", low); else n_pass++;
    n_checks++; if (low !== TICKS * CLK_DIV + 1) $display("FAIL goign_end_low: got %0d want %0d", low, TICKS * CLK_DIV + 1); else n_pass++;
    n_checks++; if (n_start - st0 !== 1) $display("FAIL goign_starts: got %0d want 1", n_start - st0); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (bytes[b0 + k] !== exp_b[k]) $display("FAIL goign_byte%0d: got %02h want %02h", k, bytes[b0 + k], exp_b[k]);
      else n_pass++;
    end
    repeat (40) @(negedge CLOCK);
    n_checks++; if (end_o !== 1'b1) $display("FAIL goign_queued: got END=%b want 1", end_o); else n_pass++;
    $display("xfer go_ignored low=%0d starts=%0d", low, n_start - st0);
  endtask

  task automatic test_reset_mid();
    int low, st0, sp0, b0;
    bit tout;
    logic [23:0] d;
    do_transfer(24'h341201, 3'b001, 2, low, st0, sp0, b0, tout);
    n_checks++; if (tout) $display("FAIL rstmid_no_start: END never fell"); else n_pass++;
    rst_n = 1'b0;
    n_checks++;
    if (scl !== 1'b1 || sda_oe !== 1'b0 || end_o !== 1'b1 || ack_err !== 1'b0)
      $display("FAIL rstmid_outputs: got SCL=%b SDA_OE=%b END=%b ACK_ERR=%b want 1 0 1 0", scl, sda_oe, end_o, ack_err);
    else n_pass++;
    repeat (2) @(negedge CLOCK);
    rst_n = 1'b1;
    repeat (40) @(negedge CLOCK);
    n_checks++; if (end_o !== 1'b1) $display("FAIL rstmid_go_held: got END=%b want 1", end_o); else n_pass++;
    $display("xfer reset_mid END=%b after release with GO held", end_o);
    d = 24'($urandom());
    do_transfer(d, 3'b000, 0, low, st0, sp0, b0, tout);
    n_checks++; if (tout || low !== TICKS * CLK_DIV + 1) $display("FAIL rstmid_fresh_low: got %0d want %0d", low, TICKS * CLK_DIV + 1); else n_pass++;
    n_checks++; if (ack_err !== 1'b0) $display("FAIL rstmid_fresh_ack_err: got %b want 0", ack_err); else n_pass++;
    n_checks++; if (n_start - st0 !== 1 || n_stop - sp0 !== 1) $display("FAIL rstmid_fresh_start_stop: got %0d/%0d want 1/1", n_start - st0, n_stop - sp0); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (bytes[b0 + k] !== d[23 - 8 * k -: 8]) $display("FAIL rstmid_byte%0d: got %02h want %02h", k, bytes[b0 + k], d[23 - 8 * k -: 8]);
      else n_pass++;
    end
    $display("xfer fresh_after_reset data=%06h low=%0d", d, low);
  endtask

  initial begin
    rst_n = 1'b0;
    GO    = 1'b0;
    repeat (5) @(negedge CLOCK);
    test_reset();
    rst_n = 1'b1;
    repeat (5) @(negedge CLOCK);
    test_basic();
    test_nack();
    test_random();
    test_go_ignored();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
